// File: rtl/fetch_issue_queue.sv
// Instruction buffer between fetch and dual-issue decode: accepts fetch groups,
// presents the oldest instructions in program order, and is flushed on redirect.
module fetch_issue_queue #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           fetch_valid,
  input  logic [XLEN-1:0]                fetch_pc,
  input  logic [FETCH_W*32-1:0]          fetch_instr,
  input  logic [FETCH_W-1:0]             fetch_mask,
  output logic                           fetch_ready,
  output logic [ISSUE_W-1:0]             issue_valid,
  output logic [ISSUE_W*32-1:0]          issue_instr,
  output logic [ISSUE_W*XLEN-1:0]        issue_pc,
  input  logic [$clog2(ISSUE_W+1)-1:0]   issue_take,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy,
  output logic                           err
);

  localparam int unsigned ptrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned cntW = $clog2(DEPTH + 1);
  localparam logic [31:0] nopInstr = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } entryT;

  entryT           mem [DEPTH];
  logic [ptrW-1:0] head;
  logic [ptrW-1:0] tail;
  logic [cntW-1:0] count;

  logic [cntW-1:0] runLen;
  logic            runBroken;
  logic [cntW-1:0] pushN;
  logic [cntW-1:0] popK;
  logic            pushFire;
  logic            overTake;
  logic            overflowErr;
  logic            underflowErr;

  // Only the contiguous run of valid slots starting at slot 0 is accepted
  always_comb begin
    runLen    = '0;
    runBroken = 1'b0;
    for (int i = 0; i < int'(FETCH_W); i++) begin
      if (!runBroken && fetch_mask[i]) begin
        runLen = runLen + cntW'(1);
      end else begin
        runBroken = 1'b1;
      end
    end
  end

  // Conservative: ignores any pop happening in the same cycle
  assign fetch_ready  = (32'(DEPTH) - 32'(count)) >= 32'(FETCH_W);
  assign pushFire     = fetch_valid & fetch_ready & ~flush;
  assign overTake     = 32'(issue_take) > 32'(count);
  assign overflowErr  = fetch_valid & ~fetch_ready & ~flush;
  assign underflowErr = overTake & ~flush;
  assign pushN        = pushFire ? runLen : '0;
  assign popK         = overTake ? count : cntW'(issue_take);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        head  <= head + ptrW'(popK);
        tail  <= tail + ptrW'(pushN);
        count <= count + pushN - popK;
      end
      if (overflowErr || underflowErr) begin
        err <= 1'b1;
      end
    end
  end

  // Entry storage needs no reset: issue slots are gated by count
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(FETCH_W); i++) begin
      if (pushFire && (32'(i) < 32'(runLen))) begin
        mem[tail + ptrW'(i)] <= '{instr: fetch_instr[32*i +: 32],
                                  pc:    fetch_pc + XLEN'(4 * i)};
      end
    end
  end

  always_comb begin
    issue_valid = '0;
    issue_instr = {ISSUE_W{nopInstr}};
    issue_pc    = '0;
    for (int j = 0; j < int'(ISSUE_W); j++) begin
      if (32'(j) < 32'(count)) begin
        issue_valid[j]             = 1'b1;
        issue_instr[32*j +: 32]    = mem[head + ptrW'(j)].instr;
        issue_pc[XLEN*j +: XLEN]   = mem[head + ptrW'(j)].pc;
      end
    end
  end

  assign occupancy = count;

endmodule

// File: tb/tb_fetch_issue_queue.sv
// Scoreboard bench for fetch_issue_queue: a queue model tracks accepted
// instructions and each scenario task checks the issue window against it.
module tb_fetch_issue_queue;

  localparam int unsigned XLEN = 32;
  localparam int unsigned FW   = 2;
  localparam int unsigned IW   = 2;
  localparam int unsigned D    = 8;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              flush = 1'b0;
  logic              fetch_valid = 1'b0;
  logic [XLEN-1:0]   fetch_pc = '0;
  logic [FW*32-1:0]  fetch_instr = '0;
  logic [FW-1:0]     fetch_mask = '0;
  logic              fetch_ready;
  logic [IW-1:0]     issue_valid;
  logic [IW*32-1:0]  issue_instr;
  logic [IW*XLEN-1:0] issue_pc;
  logic [1:0]        issue_take = '0;
  logic [3:0]        occupancy;
  logic              err;

  ent_t sbq[$];
  logic mErr = 1'b0;
  int   total = 0;
  int   bad = 0;

  fetch_issue_queue #(.XLEN(XLEN), .FETCH_W(FW), .ISSUE_W(IW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .flush(flush), .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc), .fetch_instr(fetch_instr), .fetch_mask(fetch_mask),
    .fetch_ready(fetch_ready), .issue_valid(issue_valid), .issue_instr(issue_instr),
    .issue_pc(issue_pc), .issue_take(issue_take), .occupancy(occupancy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of stimulus and advance the reference model across the edge
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [63:0] ins,
                       input logic [1:0] mask, input logic [1:0] take, input logic fl);
    int  n, k, sz;
    bit  rdy;
    fetch_valid = v; fetch_pc = pc; fetch_instr = ins; fetch_mask = mask;
    issue_take = take; flush = fl;
    sz  = sbq.size();
    rdy = (int'(D) - sz) >= int'(FW);
    @(posedge clk); #1;
    if (fl) begin
      sbq.delete();
    end else begin
      if (v && !rdy) mErr = 1'b1;
      if (int'(take) > sz) mErr = 1'b1;
      k = (int'(take) > sz) ? sz : int'(take);
      repeat (k) void'(sbq.pop_front());
      if (v && rdy) begin
        n = 0;
        while (n < int'(FW) && mask[n]) n++;
        for (int i = 0; i < n; i++) sbq.push_back('{instr: ins[32*i +: 32], pc: pc + 32'(4*i)});
      end
    end
    fetch_valid = 1'b0; fetch_mask = '0; issue_take = '0; flush = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", fetch_ready); end
    total++; if (issue_valid !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b exp=00", issue_valid); end
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    total++; if (issue_instr !== {NOP, NOP}) begin bad++; $display("FAIL reset_instr got=%h exp=%h", issue_instr, {NOP, NOP}); end
    total++; if (issue_pc !== 64'd0) begin bad++; $display("FAIL reset_pc got=%h exp=0", issue_pc); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", err); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    ent_t e0, e1;
    cycle(1'b1, 32'h100, {32'h00A00113, 32'h00500093}, 2'b11, 2'd0, 1'b0);
    total++; if (issue_valid !== 2'b11) begin bad++; $display("FAIL basic_valid got=%b exp=11", issue_valid); end
    total++; if (issue_pc !== {32'h104, 32'h100}) begin bad++; $display("FAIL basic_pc got=%h exp=%h", issue_pc, {32'h104, 32'h100}); end
    total++; if (occupancy !== 4'd2) begin bad++; $display("FAIL basic_occ got=%0d exp=2", occupancy); end
    total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%0b exp=1", fetch_ready); end
    e0 = sbq[0]; e1 = sbq[1];
    total++; if (issue_instr !== {e1.instr, e0.instr}) begin bad++; $display("FAIL basic_instr got=%h exp=%h", issue_instr, {e1.instr, e0.instr}); end
    cycle(1'b0, 32'h0, 64'h0, 2'b00, 2'd2, 1'b0);
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL basic_drain got=%0d exp=0", occupancy); end
  endtask

  task automatic test_full();
    ent_t e;
    for (int g = 0; g < 4; g++)
      cycle(1'b1, 32'h400 + 32'(8*g), {32'hB000_0000 + 32'(2*g+1), 32'hB000_0000 + 32'(2*g)}, 2'b11, 2'd0, 1'b0);
    total++; if (occupancy !== 4'd8) begin bad++; $display("FAIL full_occ got=%0d exp=8", occupancy); end
    total++; if (fetch_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b exp=0", fetch_ready); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL full_err_pre got=%0b exp=0", err); end
    cycle(1'b1, 32'h900, {32'hDEAD_BEEF, 32'hDEAD_BEEF}, 2'b11, 2'd0, 1'b0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL full_overflow_err got=%0b exp=1", err); end
    total++; if (occupancy !== 4'd8) begin bad++; $display("FAIL full_overflow_occ got=%0d exp=8", occupancy); end
    for (int i = 0; i < 4; i++) begin
      e = sbq[0];
      total++; if (issue_pc[31:0] !== 32'h400 + 32'(8*i) || e.pc !== 32'h400 + 32'(8*i)) begin bad++; $display("FAIL full_drain_pc got=%h exp=%h", issue_pc[31:0], 32'h400 + 32'(8*i)); end
      total++; if (issue_instr[31:0] !== e.instr || issue_instr[63:32] !== sbq[1].instr) begin bad++; $display("FAIL full_drain_instr got=%h exp=%h", issue_instr, {sbq[1].instr, e.instr}); end
      cycle(1'b0, 32'h0, 64'h0, 2'b00, 2'd2, 1'b0);
    end
    total++; if (occupancy !== 4'd0 || err !== 1'b1) begin bad++; $display("FAIL full_after got occ=%0d err=%0b exp occ=0 err=1", occupancy, err); end
  endtask

  task automatic test_steady();
    logic [31:0] expPc;
    cycle(1'b1, 32'h0, {32'hA000_0004, 32'hA000_0000}, 2'b11, 2'd0, 1'b0);
    expPc = 32'h0;
    for (int c = 0; c < 10; c++) begin
      total++; if (issue_valid !== 2'b11) begin bad++; $display("FAIL steady_valid c=%0d got=%b exp=11", c, issue_valid); end
      total++; if (issue_pc !== {expPc + 32'h4, expPc}) begin bad++; $display("FAIL steady_pc c=%0d got=%h exp=%h", c, issue_pc, {expPc + 32'h4, expPc}); end
      total++; if (issue_instr !== {sbq[1].instr, sbq[0].instr}) begin bad++; $display("FAIL steady_instr c=%0d got=%h exp=%h", c, issue_instr, {sbq[1].instr, sbq[0].instr}); end
      cycle(1'b1, 32'(8*(c+1)), {32'hA000_0004 + 32'(8*(c+1)), 32'hA000_0000 + 32'(8*(c+1))}, 2'b11, 2'd2, 1'b0);
      expPc = expPc + 32'h8;
      total++; if (occupancy !== 4'd2) begin bad++; $display("FAIL steady_occ c=%0d got=%0d exp=2", c, occupancy); end
    end
    cycle(1'b0, 32'h0, 64'h0, 2'b00, 2'd2, 1'b0);
  endtask

  task automatic test_flush();
    cycle(1'b1, 32'h500, {32'hC000_0001, 32'hC000_0000}, 2'b11, 2'd0, 1'b0);
    cycle(1'b1, 32'h508, {32'hC000_0003, 32'hC000_0002}, 2'b11, 2'd0, 1'b0);
    cycle(1'b1, 32'h510, {32'hC000_0005, 32'hC000_0004}, 2'b01, 2'd0, 1'b0);
    total++; if (occupancy !== 4'd5) begin bad++; $display("FAIL flush_pre_occ got=%0d exp=5", occupancy); end
    cycle(1'b1, 32'h518, {32'hC000_0007, 32'hC000_0006}, 2'b11, 2'd1, 1'b1);
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    total++; if (issue_valid !== 2'b00) begin bad++; $display("FAIL flush_valid got=%b exp=00", issue_valid); end
    total++; if (issue_instr !== {NOP, NOP}) begin bad++; $display("FAIL flush_instr got=%h exp=%h", issue_instr, {NOP, NOP}); end
    total++; if (err !== mErr) begin bad++; $display("FAIL flush_err got=%0b exp=%0b", err, mErr); end
    cycle(1'b1, 32'h200, {32'hC000_0009, 32'hC000_0008}, 2'b11, 2'd0, 1'b0);
    total++; if (issue_pc[31:0] !== 32'h200) begin bad++; $display("FAIL flush_repush_pc got=%h exp=200", issue_pc[31:0]); end
    total++; if (issue_instr[31:0] !== sbq[0].instr) begin bad++; $display("FAIL flush_repush_instr got=%h exp=%h", issue_instr[31:0], sbq[0].instr); end
    cycle(1'b0, 32'h0, 64'h0, 2'b00, 2'd2, 1'b0);
  endtask

  task automatic test_mask();
    cycle(1'b1, 32'h300, {32'hE000_0001, 32'hE000_0000}, 2'b01, 2'd0, 1'b0);
    total++; if (occupancy !== 4'd1) begin bad++; $display("FAIL mask01_occ got=%0d exp=1", occupancy); end
    total++; if (issue_valid !== 2'b01) begin bad++; $display("FAIL mask01_valid got=%b exp=01", issue_valid); end
    total++; if (issue_pc !== {32'h0, 32'h300}) begin bad++; $display("FAIL mask01_pc got=%h exp=%h", issue_pc, {32'h0, 32'h300}); end
    total++; if (issue_instr !== {NOP, 32'hE000_0000}) begin bad++; $display("FAIL mask01_instr got=%h exp=%h", issue_instr, {NOP, 32'hE000_0000}); end
    cycle(1'b1, 32'h340, {32'hE000_0003, 32'hE000_0002}, 2'b10, 2'd0, 1'b0);
    total++; if (occupancy !== 4'd1 || occupancy !== 4'(sbq.size())) begin bad++; $display("FAIL mask10_occ got=%0d exp=1", occupancy); end
    total++; if (issue_pc[31:0] !== 32'h300) begin bad++; $display("FAIL mask10_pc got=%h exp=300", issue_pc[31:0]); end
    cycle(1'b0, 32'h0, 64'h0, 2'b00, 2'd1, 1'b0);
  endtask

  task automatic test_overtake_reset();
    #2 reset = 1'b0;
    #4 reset = 1'b1;
    mErr = 1'b0; sbq.delete();
    @(posedge clk); #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL ot_clear_err got=%0b exp=0", err); end
    cycle(1'b1, 32'h600, {32'hF000_0001, 32'hF000_0000}, 2'b01, 2'd0, 1'b0);
    cycle(1'b0, 32'h0, 64'h0, 2'b00, 2'd2, 1'b0);
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL ot_occ got=%0d exp=0", occupancy); end
    total++; if (err !== 1'b1 || mErr !== 1'b1) begin bad++; $display("FAIL ot_err got=%0b exp=1", err); end
    cycle(1'b1, 32'h700, {32'hF000_0003, 32'hF000_0002}, 2'b11, 2'd0, 1'b0);
    total++; if (occupancy !== 4'd2) begin bad++; $display("FAIL ot_refill got=%0d exp=2", occupancy); end
    #2 reset = 1'b0;
    #1;
    sbq.delete(); mErr = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL midreset_err got=%0b exp=0", err); end
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL midreset_occ got=%0d exp=0", occupancy); end
    total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%0b exp=1", fetch_ready); end
    total++; if (issue_valid !== 2'b00) begin bad++; $display("FAIL midreset_valid got=%b exp=00", issue_valid); end
    #2 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_steady();
    test_flush();
    test_mask();
    test_overtake_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
